bf_fetch: RTL
=============

// Module: bf_fetch
// PURPOSE
//  Instruction fetch/loop-control stage of the bfX core. Drives the read-only instruction port of
//  mem (addr2/out2; registered read, 1-cycle latency) and walks the program from START_ADDR. Skips
//  comment bytes, issues the 6 data ops to the execute stage over a valid/ready handshake and
//  resolves '['/']' itself, scanning memory for the matching bracket.
// PARAMETERS
//  START_ADDR   16'h0000  PC after reset
//  CODE_END     16'h0100  first address past the code region; scans reaching it -> error
//  DEPTH_W      8         width of the bracket nesting counter
//  STACK_DEPTH  16        loop return-stack entries (LOOP_STACK_EN only)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   asynchronous, active-high reset
//  imem_addr  out  16  to mem addr2; registered, always equals PC
//  imem_data  in   8   from mem out2; byte at the imem_addr held during the previous edge
//  ins_valid  out  1   decoded data op offered to execute
//  ins_ready  in   1   execute accepts op (transfer = valid & ready on posedge)
//  ins_op     out  3   0 '+', 1 '-', 2 '>', 3 '<', 4 '.', 5 ','
//  exec_idle  in   1   execute holds no outstanding op; cell_zero is valid
//  cell_zero  in   1   current data cell == 0
//  halted     out  1   program ended (0x00 fetched) or error
//  err        out  1   unmatched bracket / nesting overflow / stack overflow
// BEHAVIOUR
//  - Reset (async, any state): imem_addr=START_ADDR, ins_valid=0, ins_op=0, halted=0, err=0,
//    depth=0, state=WAIT.
//  - States: WAIT (1 cycle; data for imem_addr returns) -> DEC. DEC decodes imem_data:
//    * '+','-','>','<','.',',' (2B,2D,3E,3C,2E,2C): ins_valid=1 with ins_op; hold op and PC
//      until ins_ready; on transfer PC+1 -> WAIT. Best case 2 cycles/op.
//    * '[' (5B) / ']' (5D): stay in DEC until exec_idle=1, then sample cell_zero:
//      '[' & zero -> SCAN_F, depth=1, PC+1; '[' & nonzero -> PC+1 -> WAIT;
//      ']' & zero -> PC+1 -> WAIT; ']' & nonzero -> SCAN_B, depth=1, PC-1.
//    * 0x00 -> HALT (halted=1). Any other byte: comment, PC+1 -> WAIT.
//  - Scans alternate wait/compare cycles (2 cycles per byte). SCAN_F: '[' depth+1, ']' depth-1;
//    depth reaching 0 -> PC=match+1 -> WAIT. SCAN_B mirrors ('[' decrements); on 0 -> PC=match+1.
//  - ins_valid is never asserted outside DEC; brackets/comments are never forwarded.
//  - Boundaries: SCAN_F reaching CODE_END or 0x00, SCAN_B needing PC-1 at PC==0, or depth
//    increment at all-ones -> HALT with err=1. Sequential PC+1 reaching CODE_END -> HALT, err=0.
//  - HALT is terminal until rst; imem_addr frozen, ins_valid=0.
//  - exec_idle/cell_zero are ignored outside bracket evaluation in DEC.
// CONFIGURATION
//  LOOP_STACK_EN defined: STACK_DEPTH x 16 return stack of '[' addresses. '[' & nonzero pushes
//   PC; ']' & nonzero sets PC=top+1 in one step (no SCAN_B); ']' & zero pops. '[' & zero still
//   uses SCAN_F (no push). Push when full -> HALT, err=1. Pop when empty -> HALT, err=1.
//   Stack cleared on rst.
//  Undefined: no stack; ']' & nonzero always uses SCAN_B as above.
// TESTING
//  1 code "+-><.,"@0, ins_ready=1 -> ops 0,1,2,3,4,5 issued, one per 2 cycles; then 0x00 -> halted=1.
//  2 "+ab\n-"@0 -> only ops 0,1 issued; comment bytes produce no ins_valid; PC reaches 5.
//  3 "[+[-]]>"@0, exec_idle=1, cell_zero=1 -> SCAN_F, first issued op is 2 ('>') from addr 6.
//  4 "+[-]"@0, cell_zero=0 on first ']' then 1 -> '-' issued twice, PC ends at 4; exec_idle=0
//    on a bracket stalls DEC with imem_addr unchanged; ins_ready=0 holds ins_valid/ins_op.
//  5 "[[+]"@0, cell_zero=1 -> scan hits 0x00 -> halted=1, err=1.
//  6 rst asserted mid-SCAN_F -> next cycle imem_addr=START_ADDR, ins_valid=0, err=0, halted=0;
//    with LOOP_STACK_EN, 17 nested '[' with nonzero cell -> err=1.

Source files
------------

// File: rtl/bf_fetch.sv
// bfX instruction fetch / loop control: walks program memory, issues data ops, resolves brackets.
// Optional LOOP_STACK_EN adds a return stack of '[' addresses so ']' jumps back in one step.
module bf_fetch #(
  parameter logic [15:0] START_ADDR  = 16'h0000,
  parameter logic [15:0] CODE_END    = 16'h0100,
  parameter int          DEPTH_W     = 8,
  parameter int          STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [7:0]  imem_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [2:0]  ins_op,
  input  logic        exec_idle,
  input  logic        cell_zero,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_WAIT, S_DEC, S_SFW, S_SFC, S_SBW, S_SBC, S_HALT
  } state_t;

  state_t               state_r, state_n;
  logic [15:0]          pc_r, pc_n;
  logic [DEPTH_W-1:0]   depth_r, depth_n;
  logic                 halted_r, halted_n, err_r, err_n;
  logic [15:0]          pc_inc_s, jump_pc_s;
  logic                 adv_s, fwd_s, back_s, fail_s, jump_s, push_s, pop_s;
  logic                 full_s, empty_s;
  logic [15:0]          top_s;
  logic [3:0]           dec_s;

  // {is_data_op, op_code}
  function automatic logic [3:0] decode_op(input logic [7:0] b);
    case (b)
      8'h2B:   decode_op = 4'b1_000;
      8'h2D:   decode_op = 4'b1_001;
      8'h3E:   decode_op = 4'b1_010;
      8'h3C:   decode_op = 4'b1_011;
      8'h2E:   decode_op = 4'b1_100;
      8'h2C:   decode_op = 4'b1_101;
      default: decode_op = 4'b0_000;
    endcase
  endfunction

  assign dec_s     = decode_op(imem_data);
  assign pc_inc_s  = pc_r + 16'd1;
  assign jump_pc_s = top_s + 16'd1;
  assign imem_addr = pc_r;
  assign halted    = halted_r;
  assign err       = err_r;
  assign ins_valid = (state_r == S_DEC) && dec_s[3];
  assign ins_op    = ins_valid ? dec_s[2:0] : 3'd0;

`ifdef LOOP_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  logic [15:0]     stack_r [STACK_DEPTH];
  logic [SP_W-1:0] sp_r;
  logic [IDX_W-1:0] top_idx_s;

  assign full_s    = (sp_r == SP_W'(STACK_DEPTH));
  assign empty_s   = (sp_r == {SP_W{1'b0}});
  assign top_idx_s = sp_r[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1};
  assign top_s     = stack_r[top_idx_s];

  // Return stack of '[' addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r <= {SP_W{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) stack_r[i] <= 16'h0000;
    end else if (push_s) begin
      stack_r[sp_r[IDX_W-1:0]] <= pc_r;
      sp_r <= sp_r + {{(SP_W-1){1'b0}}, 1'b1};
    end else if (pop_s) begin
      sp_r <= sp_r - {{(SP_W-1){1'b0}}, 1'b1};
    end else begin
      sp_r <= sp_r;
    end
  end
`else
  assign full_s  = 1'b0;
  assign empty_s = 1'b1;
  assign top_s   = 16'h0000;
`endif

  // Next-state: the case picks an action, the tail applies PC/HALT effects
  always_comb begin
    state_n  = state_r;
    pc_n     = pc_r;
    depth_n  = depth_r;
    halted_n = halted_r;
    err_n    = err_r;
    adv_s = 1'b0; fwd_s = 1'b0; back_s = 1'b0; fail_s = 1'b0;
    jump_s = 1'b0; push_s = 1'b0; pop_s = 1'b0;
    case (state_r)
      S_WAIT: state_n = S_DEC;
      S_DEC: begin
        if (dec_s[3]) begin
          adv_s = ins_ready;
        end else if (imem_data == 8'h5B || imem_data == 8'h5D) begin
          if (!exec_idle) begin
            adv_s = 1'b0;
          end else if (imem_data == 8'h5B && cell_zero) begin
            depth_n = DEPTH_W'(1);
            fwd_s   = 1'b1;
          end else if (imem_data == 8'h5B) begin
`ifdef LOOP_STACK_EN
            fail_s = full_s;
            push_s = !full_s;
            adv_s  = !full_s;
`else
            adv_s = 1'b1;
`endif
          end else if (cell_zero) begin
`ifdef LOOP_STACK_EN
            fail_s = empty_s;
            pop_s  = !empty_s;
            adv_s  = !empty_s;
`else
            adv_s = 1'b1;
`endif
          end else begin
`ifdef LOOP_STACK_EN
            fail_s = empty_s;
            jump_s = !empty_s;
`else
            depth_n = DEPTH_W'(1);
            back_s  = 1'b1;
`endif
          end
        end else if (imem_data == 8'h00) begin
          state_n  = S_HALT;
          halted_n = 1'b1;
        end else begin
          adv_s = 1'b1;
        end
      end
      S_SFW: state_n = S_SFC;
      S_SFC: begin
        if (imem_data == 8'h00) begin
          fail_s = 1'b1;
        end else if (imem_data == 8'h5B) begin
          fail_s  = &depth_r;
          fwd_s   = !(&depth_r);
          depth_n = depth_r + DEPTH_W'(1);
        end else if (imem_data == 8'h5D) begin
          depth_n = depth_r - DEPTH_W'(1);
          adv_s   = (depth_r == DEPTH_W'(1));
          fwd_s   = (depth_r != DEPTH_W'(1));
        end else begin
          fwd_s = 1'b1;
        end
      end
      S_SBW: state_n = S_SBC;
      S_SBC: begin
        if (imem_data == 8'h5D) begin
          fail_s  = &depth_r;
          back_s  = !(&depth_r);
          depth_n = depth_r + DEPTH_W'(1);
        end else if (imem_data == 8'h5B) begin
          depth_n = depth_r - DEPTH_W'(1);
          adv_s   = (depth_r == DEPTH_W'(1));
          back_s  = (depth_r != DEPTH_W'(1));
        end else begin
          back_s = 1'b1;
        end
      end
      S_HALT: state_n = S_HALT;
      default: begin
        state_n  = S_HALT;
        halted_n = 1'b1;
        err_n    = 1'b1;
      end
    endcase

    // A scan step that would leave the code region is an error; a plain step past it is a clean end
    if (fwd_s && pc_inc_s == CODE_END) begin
      fail_s = 1'b1;
    end else if (back_s && pc_r == 16'h0000) begin
      fail_s = 1'b1;
    end else begin
      fail_s = fail_s;
    end

    if (fail_s) begin
      state_n  = S_HALT;
      halted_n = 1'b1;
      err_n    = 1'b1;
    end else if (fwd_s) begin
      pc_n    = pc_inc_s;
      state_n = S_SFW;
    end else if (back_s) begin
      pc_n    = pc_r - 16'd1;
      state_n = S_SBW;
    end else if (jump_s) begin
      pc_n    = jump_pc_s;
      state_n = S_WAIT;
    end else if (adv_s && pc_inc_s == CODE_END) begin
      state_n  = S_HALT;
      halted_n = 1'b1;
    end else if (adv_s) begin
      pc_n    = pc_inc_s;
      state_n = S_WAIT;
    end else begin
      pc_n = pc_n;
    end
  end

  // State, PC and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_WAIT;
      pc_r     <= START_ADDR;
      depth_r  <= {DEPTH_W{1'b0}};
      halted_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      pc_r     <= pc_n;
      depth_r  <= depth_n;
      halted_r <= halted_n;
      err_r    <= err_n;
    end
  end

endmodule
